// File: rtl/ls_unit.sv
// ls_unit: load/store execution unit.
//
// Accepts one memory op at a time from the load/store buffer through the
// LSreadEn/LSworkEn handshake. The op then runs as a sequence of single-byte
// transfers on the memory-controller port. Loads are assembled little-endian,
// sign- or zero-extended, and broadcast on the LS result bus. Every op,
// including a NOP, ends with a one-cycle LSdone pulse.
//
// Ports
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   rdy               global enable; when low, all state and registered outputs hold
//   LSworkEn          op valid from the buffer (single cycle)
//   operandO, imm     base address and sign-extended offset (effective addr = sum)
//   operandT          store data
//   wrtTag, wrtName   destination rename tag and architectural register
//   opCode            [2:0] funct3, [3] 1 = store / 0 = load
//   LSreadEn          unit can accept an op this cycle
//   LSdone            op retired (pulse)
//   enLSwrt           load result valid (pulse) with LStag/LSname/LSdata
//   memReq/memWr      byte request and direction (1 = write)
//   memAddr/memWData  byte address and write byte
//   memAck/memRData   request accepted; read byte valid in the same cycle

module ls_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned NAME_W = 5,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,

    input  logic              LSworkEn,
    input  logic [DATA_W-1:0] operandO,
    input  logic [DATA_W-1:0] operandT,
    input  logic [DATA_W-1:0] imm,
    input  logic [TAG_W-1:0]  wrtTag,
    input  logic [NAME_W-1:0] wrtName,
    input  logic [OP_W-1:0]   opCode,
    output logic              LSreadEn,

    output logic              LSdone,
    output logic              enLSwrt,
    output logic [TAG_W-1:0]  LStag,
    output logic [NAME_W-1:0] LSname,
    output logic [DATA_W-1:0] LSdata,

    output logic              memReq,
    output logic              memWr,
    output logic [DATA_W-1:0] memAddr,
    output logic [7:0]        memWData,
    input  logic              memAck,
    input  logic [7:0]        memRData
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rbuf_q;
    logic [OP_W-1:0]   op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [NAME_W-1:0] name_q;
    logic [1:0]        cnt_q;

    logic [1:0]        last_cnt;
    logic [DATA_W-1:0] rbuf_next;
    logic [DATA_W-1:0] load_result;
    logic              is_store;

    assign is_store = op_q[3];

    // Index of the final byte of the access (N-1). Size code 3 never reaches
    // StAccess, so its value here is irrelevant.
    always_comb begin
        last_cnt = 2'd0;
        case (op_q[1:0])
            2'd0:    last_cnt = 2'd0;
            2'd1:    last_cnt = 2'd1;
            2'd2:    last_cnt = 2'd3;
            default: last_cnt = 2'd0;
        endcase
    end

    // Read buffer with the byte arriving this cycle merged in, so the final
    // ack can produce the complete result without an extra cycle.
    always_comb begin
        rbuf_next = rbuf_q;
        rbuf_next[{cnt_q, 3'b000} +: 8] = memRData;
    end

    // op[2] selects zero extension (LBU/LHU); otherwise sign extension.
    always_comb begin
        load_result = rbuf_next;
        case (op_q[1:0])
            2'd0: load_result = {{(DATA_W-8){~op_q[2] & rbuf_next[7]}}, rbuf_next[7:0]};
            2'd1: load_result = {{(DATA_W-16){~op_q[2] & rbuf_next[15]}}, rbuf_next[15:0]};
            default: load_result = rbuf_next;
        endcase
    end

    // The buffer sees LSreadEn drop in the issue cycle, preventing back-to-back issue.
    assign LSreadEn = (state_q == StIdle) && !LSworkEn;

    // Memory port is decoded straight off the state register so memReq falls in
    // the cycle after the final ack. Outside StAccess the port is driven to zero.
    assign memReq   = (state_q == StAccess);
    assign memWr    = memReq & is_store;
    assign memAddr  = memReq ? (addr_q + DATA_W'(cnt_q)) : '0;
    assign memWData = memReq ? data_q[{cnt_q, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            rbuf_q  <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            name_q  <= '0;
            cnt_q   <= 2'd0;
            LSdone  <= 1'b0;
            enLSwrt <= 1'b0;
            LStag   <= '0;
            LSname  <= '0;
            LSdata  <= '0;
        end else if (rdy) begin
            case (state_q)
                StIdle: begin
                    if (LSworkEn) begin
                        addr_q <= operandO + imm;
                        data_q <= operandT;
                        op_q   <= opCode;
                        tag_q  <= wrtTag;
                        name_q <= wrtName;
                        cnt_q  <= 2'd0;
                        rbuf_q <= '0;
                        // Size code 3 is a NOP: no transfers, retire immediately
                        // without a result broadcast.
                        if (opCode[1:0] == 2'd3) begin
                            state_q <= StDone;
                            LSdone  <= 1'b1;
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end

                StAccess: begin
                    if (memAck) begin
                        if (!is_store) begin
                            rbuf_q <= rbuf_next;
                        end
                        if (cnt_q == last_cnt) begin
                            state_q <= StDone;
                            LSdone  <= 1'b1;
                            if (!is_store) begin
                                enLSwrt <= 1'b1;
                                LStag   <= tag_q;
                                LSname  <= name_q;
                                LSdata  <= load_result;
                            end
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end

                StDone: begin
                    // Result bus returns to zero so stores and NOPs never show stale data.
                    LSdone  <= 1'b0;
                    enLSwrt <= 1'b0;
                    LStag   <= '0;
                    LSname  <= '0;
                    LSdata  <= '0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ls_unit.sv
module tb_ls_unit;

    localparam logic [3:0] OpLb  = 4'b0000;
    localparam logic [3:0] OpLh  = 4'b0001;
    localparam logic [3:0] OpLw  = 4'b0010;
    localparam logic [3:0] OpNop = 4'b0011;
    localparam logic [3:0] OpLbu = 4'b0100;
    localparam logic [3:0] OpLhu = 4'b0101;
    localparam logic [3:0] OpSb  = 4'b1000;
    localparam logic [3:0] OpSh  = 4'b1001;
    localparam logic [3:0] OpSw  = 4'b1010;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        LSworkEn;
    logic [31:0] operandO;
    logic [31:0] operandT;
    logic [31:0] imm;
    logic [3:0]  wrtTag;
    logic [4:0]  wrtName;
    logic [3:0]  opCode;
    logic        LSreadEn;
    logic        LSdone;
    logic        enLSwrt;
    logic [3:0]  LStag;
    logic [4:0]  LSname;
    logic [31:0] LSdata;
    logic        memReq;
    logic        memWr;
    logic [31:0] memAddr;
    logic [7:0]  memWData;
    logic        memAck;
    logic [7:0]  memRData;

    logic        ack_en;
    logic [7:0]  rmem [0:4095];

    logic [31:0] log_addr [0:63];
    logic        log_wr   [0:63];
    logic [7:0]  log_wd   [0:63];
    int          log_n = 0;

    int n_checks = 0;
    int n_pass   = 0;

    ls_unit dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .LSworkEn (LSworkEn),
        .operandO (operandO),
        .operandT (operandT),
        .imm      (imm),
        .wrtTag   (wrtTag),
        .wrtName  (wrtName),
        .opCode   (opCode),
        .LSreadEn (LSreadEn),
        .LSdone   (LSdone),
        .enLSwrt  (enLSwrt),
        .LStag    (LStag),
        .LSname   (LSname),
        .LSdata   (LSdata),
        .memReq   (memReq),
        .memWr    (memWr),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memAck   (memAck),
        .memRData (memRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks whenever enabled, read data combinational from rmem.
    assign memAck   = memReq && ack_en;
    assign memRData = rmem[memAddr[11:0]];

    // Log every transfer the DUT actually consumes.
    always @(posedge clk) begin
        if (!rst && rdy && memReq && memAck && log_n < 64) begin
            log_addr[log_n] <= memAddr;
            log_wr[log_n]   <= memWr;
            log_wd[log_n]   <= memWData;
            log_n           <= log_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the unit idle; returns at posedge+1 of the first ACCESS cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] t,
                         input logic [31:0] i, input logic [3:0] tag, input logic [4:0] name);
        opCode   = op;
        operandO = a;
        operandT = t;
        imm      = i;
        wrtTag   = tag;
        wrtName  = name;
        LSworkEn = 1'b1;
        #1;
        check("rden_drop", 32'(LSreadEn), 32'd0);
        @(posedge clk);
        #1;
        LSworkEn = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!LSdone && cycles < budget) begin
            step();
            cycles++;
        end
        check("done_seen", 32'(LSdone), 32'd1);
    endtask

    int cyc;
    int base;

    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        LSworkEn = 1'b0;
        operandO = '0;
        operandT = '0;
        imm      = '0;
        wrtTag   = '0;
        wrtName  = '0;
        opCode   = '0;
        ack_en   = 1'b1;
        for (int k = 0; k < 4096; k++) rmem[k] = 8'h00;
        rmem[12'h104] = 8'h78; rmem[12'h105] = 8'h56;
        rmem[12'h106] = 8'h34; rmem[12'h107] = 8'h12;
        rmem[12'h500] = 8'h80;
        rmem[12'h510] = 8'h01; rmem[12'h511] = 8'h80;
        rmem[12'h300] = 8'h11; rmem[12'h301] = 8'h22;
        rmem[12'h302] = 8'h33; rmem[12'h303] = 8'h44;
        rmem[12'h600] = 8'hA1; rmem[12'h601] = 8'hB2;
        rmem[12'h602] = 8'hC3; rmem[12'h603] = 8'hD4;
        rmem[12'hFFE] = 8'hAA; rmem[12'hFFF] = 8'hBB;
        rmem[12'h000] = 8'hCC; rmem[12'h001] = 8'hDD;

        step();
        step();
        rst = 1'b0;
        check("rst_rden",  32'(LSreadEn), 32'd1);
        check("rst_req",   32'(memReq),   32'd0);
        check("rst_done",  32'(LSdone),   32'd0);
        check("rst_wrt",   32'(enLSwrt),  32'd0);
        check("rst_data",  LSdata,        32'h0);
        check("rst_addr",  memAddr,       32'h0);

        // LW 0x100+4, one ack per cycle
        base = log_n;
        issue(OpLw, 32'h100, 32'h0, 32'h4, 4'd5, 5'd9);
        wait_done(20, cyc);
        check("lw_lat",   32'(cyc),     32'd4);
        check("lw_wrt",   32'(enLSwrt), 32'd1);
        check("lw_data",  LSdata,       32'h12345678);
        check("lw_tag",   32'(LStag),   32'd5);
        check("lw_name",  32'(LSname),  32'd9);
        check("lw_nbyte", 32'(log_n - base), 32'd4);
        for (int k = 0; k < 4; k++) check("lw_addr", log_addr[base + k], 32'h104 + 32'(k));
        check("lw_rden_done", 32'(LSreadEn), 32'd0);
        step();
        check("lw_rden_back", 32'(LSreadEn), 32'd1);
        check("lw_done_clr",  32'(LSdone),   32'd0);

        // Byte/half loads with sign and zero extension
        issue(OpLb, 32'h500, 32'h0, 32'h0, 4'd1, 5'd1);
        wait_done(10, cyc);
        check("lb_data", LSdata, 32'hFFFFFF80);
        step();
        issue(OpLbu, 32'h500, 32'h0, 32'h0, 4'd2, 5'd2);
        wait_done(10, cyc);
        check("lbu_data", LSdata, 32'h00000080);
        step();
        issue(OpLh, 32'h510, 32'h0, 32'h0, 4'd3, 5'd3);
        wait_done(10, cyc);
        check("lh_data", LSdata, 32'hFFFF8001);
        step();
        issue(OpLhu, 32'h50F, 32'h0, 32'h1, 4'd4, 5'd4);
        wait_done(10, cyc);
        check("lhu_data", LSdata, 32'h00008001);
        step();

        // SH with negative offset
        base = log_n;
        issue(OpSh, 32'h200, 32'hAABBCCDD, 32'hFFFFFFFE, 4'd6, 5'd6);
        wait_done(10, cyc);
        check("sh_wrt",   32'(enLSwrt), 32'd0);
        check("sh_data",  LSdata,       32'h0);
        check("sh_tag",   32'(LStag),   32'd0);
        check("sh_nbyte", 32'(log_n - base), 32'd2);
        check("sh_a0", log_addr[base],     32'h1FE);
        check("sh_d0", 32'(log_wd[base]),  32'hDD);
        check("sh_w0", 32'(log_wr[base]),  32'd1);
        check("sh_a1", log_addr[base + 1], 32'h1FF);
        check("sh_d1", 32'(log_wd[base + 1]), 32'hCC);
        step();

        // NOP retires with no transfers
        base = log_n;
        issue(OpNop, 32'h0, 32'h0, 32'h0, 4'd7, 5'd7);
        wait_done(10, cyc);
        check("nop_lat",   32'(cyc),     32'd0);
        check("nop_wrt",   32'(enLSwrt), 32'd0);
        check("nop_nbyte", 32'(log_n - base), 32'd0);
        step();

        // Address wrap past 0xFFFFFFFF
        base = log_n;
        issue(OpLw, 32'hFFFFFFF0, 32'h0, 32'hE, 4'd8, 5'd8);
        wait_done(20, cyc);
        check("wrap_data", LSdata, 32'hDDCCBBAA);
        check("wrap_a2",   log_addr[base + 2], 32'h0);
        step();

        // Ack stall on byte 1, then rdy low
        issue(OpLw, 32'h300, 32'h0, 32'h0, 4'd10, 5'd10);
        step();
        ack_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_addr", memAddr, 32'h301);
            step();
        end
        check("stall_req", 32'(memReq), 32'd1);
        ack_en = 1'b1;
        rdy    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rdy_addr", memAddr, 32'h301);
        end
        rdy = 1'b1;
        wait_done(20, cyc);
        check("stall_data", LSdata, 32'h44332211);
        check("stall_tag",  32'(LStag), 32'd10);
        step();

        // Stray LSworkEn while busy is ignored
        check("hs_rden_idle", 32'(LSreadEn), 32'd1);
        ack_en = 1'b0;
        base   = log_n;
        issue(OpLw, 32'h600, 32'h0, 32'h0, 4'd11, 5'd11);
        opCode   = OpSb;
        operandO = 32'h700;
        wrtTag   = 4'd12;
        LSworkEn = 1'b1;
        #1;
        check("hs_rden_busy", 32'(LSreadEn), 32'd0);
        step();
        LSworkEn = 1'b0;
        ack_en   = 1'b1;
        wait_done(20, cyc);
        check("hs_data",  LSdata,     32'hD4C3B2A1);
        check("hs_tag",   32'(LStag), 32'd11);
        check("hs_nbyte", 32'(log_n - base), 32'd4);
        step();
        step();
        check("hs_no_extra", 32'(memReq), 32'd0);

        // Reset mid-store, then a normal load
        base = log_n;
        issue(OpSw, 32'h400, 32'hDEADBEEF, 32'h0, 4'd13, 5'd13);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_req",  32'(memReq),   32'd0);
        check("rst_mid_rden", 32'(LSreadEn), 32'd1);
        check("rst_mid_done", 32'(LSdone),   32'd0);
        check("rst_mid_nbyte", 32'(log_n - base), 32'd1);
        check("rst_mid_wd",   32'(log_wd[base]), 32'hEF);
        issue(OpLw, 32'h100, 32'h0, 32'h4, 4'd14, 5'd14);
        wait_done(20, cyc);
        check("post_rst_data", LSdata,     32'h12345678);
        check("post_rst_tag",  32'(LStag), 32'd14);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
